// File: rtl/write_select_if.sv
// Store bus between the CPU side and the write-select block, plus the TX byte stream.
interface write_select_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_we;
    logic [31:0] led;
    logic [31:0] seg7;
    logic        timer_load;
    logic [31:0] timer_value;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        stall;

    // CPU / consumer side: issues stores, accepts TX bytes
    modport master (
        output we, addr, wdata, tx_ready,
        input  dmem_we, led, seg7, timer_load, timer_value, tx_data, tx_valid, stall
    );

    // write_select side
    modport slave (
        input  we, addr, wdata, tx_ready,
        output dmem_we, led, seg7, timer_load, timer_value, tx_data, tx_valid, stall
    );
endinterface

// File: rtl/write_select.sv
// Store router: sends CPU stores either to data memory or to the memory-mapped
// peripheral registers (LED, SEG7, timer reload, TX byte FIFO).
module write_select #(
    parameter int FIFO_DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    write_select_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Write targets
    localparam logic [11:0] ADDR_LED   = 12'h800;
    localparam logic [11:0] ADDR_SEG7  = 12'h804;
    localparam logic [11:0] ADDR_TIMER = 12'h814;
    localparam logic [11:0] ADDR_TX    = 12'h81C;
    // Read-only registers: stores are swallowed
    localparam logic [11:0] ADDR_RO0   = 12'h808;
    localparam logic [11:0] ADDR_RO1   = 12'h80C;
    localparam logic [11:0] ADDR_RO2   = 12'h810;
    localparam logic [11:0] ADDR_RO3   = 12'h818;

    logic [11:0] off;
    logic        hit_led, hit_seg7, hit_timer, hit_tx, hit_ro;
    logic        push, pop, full;

    logic [31:0]      led;
    logic [31:0]      seg7;
    logic [31:0]      timer_value;
    logic             timer_load;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rptr, wptr;
    logic [CNT_W-1:0] count;

    assign off = bus.addr[11:0];

    // Address decode and combinational bus outputs
    always_comb begin
        hit_led   = (off == ADDR_LED);
        hit_seg7  = (off == ADDR_SEG7);
        hit_timer = (off == ADDR_TIMER);
        hit_tx    = (off == ADDR_TX);
        hit_ro    = (off == ADDR_RO0) || (off == ADDR_RO1) ||
                    (off == ADDR_RO2) || (off == ADDR_RO3);
        full      = (count == FULL_CNT);
        bus.dmem_we = bus.we & ~(hit_led | hit_seg7 | hit_timer | hit_tx | hit_ro);
        // full comes from the registered count only: a same-cycle pop never unstalls
        bus.stall   = bus.we & hit_tx & full;
        push        = bus.we & hit_tx & ~full & ~rst;
        pop         = (count != '0) & bus.tx_ready;
    end

    // Peripheral registers; timer_load is a one-cycle registered pulse per store
    always_ff @(posedge clk) begin
        if (rst) begin
            led         <= '0;
            seg7        <= '0;
            timer_value <= '0;
            timer_load  <= 1'b0;
        end else begin
            if (bus.we && hit_led) begin
                led <= bus.wdata;
            end
            if (bus.we && hit_seg7) begin
                seg7 <= bus.wdata;
            end
            if (bus.we && hit_timer) begin
                timer_value <= bus.wdata;
            end
            timer_load <= bus.we && hit_timer;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= bus.wdata[7:0];
        end
    end

    assign bus.led         = led;
    assign bus.seg7        = seg7;
    assign bus.timer_value = timer_value;
    assign bus.timer_load  = timer_load;
    assign bus.tx_valid    = (count != '0);
    assign bus.tx_data     = mem[rptr];

endmodule

// File: tb/tb_write_select.sv
// Directed self-checking bench for write_select.
module tb_write_select;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    write_select_if bus();

    write_select #(.FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        #1;
    endtask

    initial begin
        logic [7:0] drain [4];
        drain[0] = 8'h42; drain[1] = 8'h43; drain[2] = 8'h44; drain[3] = 8'h45;

        rst = 1'b1;
        bus.tx_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_led", bus.led, 32'h0);
        check("rst_seg7", bus.seg7, 32'h0);
        check("rst_tval", bus.timer_value, 32'h0);
        check("rst_tload", {31'h0, bus.timer_load}, 32'h0);
        check("rst_txvalid", {31'h0, bus.tx_valid}, 32'h0);
        rst = 1'b0;

        // LED then SEG7
        drive(1'b1, 32'h800, 32'h12345678);
        check("led_dmem", {31'h0, bus.dmem_we}, 32'h0);
        tick();
        check("led_val", bus.led, 32'h12345678);
        drive(1'b1, 32'h804, 32'hA5);
        check("seg7_dmem", {31'h0, bus.dmem_we}, 32'h0);
        tick();
        check("seg7_val", bus.seg7, 32'hA5);
        check("seg7_led_kept", bus.led, 32'h12345678);

        // Timer reload pulse
        drive(1'b1, 32'h814, 32'd1000);
        check("tmr_dmem", {31'h0, bus.dmem_we}, 32'h0);
        tick();
        check("tmr_val", bus.timer_value, 32'd1000);
        check("tmr_load1", {31'h0, bus.timer_load}, 32'h1);
        drive(1'b0, 32'h814, 32'd0);
        tick();
        check("tmr_load0", {31'h0, bus.timer_load}, 32'h0);

        // Memory stores: plain RAM and unmatched peripheral window
        drive(1'b1, 32'h000, 32'hCAFEBABE);
        check("mem0_dmem", {31'h0, bus.dmem_we}, 32'h1);
        tick();
        drive(1'b1, 32'h820, 32'hCAFEBABE);
        check("mem820_dmem", {31'h0, bus.dmem_we}, 32'h1);
        tick();
        check("mem_led_kept", bus.led, 32'h12345678);
        check("mem_seg7_kept", bus.seg7, 32'hA5);
        check("mem_tval_kept", bus.timer_value, 32'd1000);
        drive(1'b0, 32'h000, 32'h0);
        check("idle_dmem", {31'h0, bus.dmem_we}, 32'h0);

        // Back-to-back timer stores
        drive(1'b1, 32'h814, 32'd5);
        tick();
        check("b2b_load_a", {31'h0, bus.timer_load}, 32'h1);
        check("b2b_val_a", bus.timer_value, 32'd5);
        drive(1'b1, 32'h814, 32'd7);
        tick();
        check("b2b_load_b", {31'h0, bus.timer_load}, 32'h1);
        check("b2b_val_b", bus.timer_value, 32'd7);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("b2b_load_end", {31'h0, bus.timer_load}, 32'h0);

        // Read-only register store is dropped
        drive(1'b1, 32'h80C, 32'hFFFFFFFF);
        check("ro_dmem", {31'h0, bus.dmem_we}, 32'h0);
        check("ro_stall", {31'h0, bus.stall}, 32'h0);
        tick();
        check("ro_led", bus.led, 32'h12345678);
        check("ro_seg7", bus.seg7, 32'hA5);
        check("ro_tval", bus.timer_value, 32'd7);
        check("ro_txvalid", {31'h0, bus.tx_valid}, 32'h0);

        // Fill the FIFO, stall on the fifth byte, release with one pop
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h81C, 32'hFFFFFF41 + i);
            check("fill_stall", {31'h0, bus.stall}, 32'h0);
            check("fill_dmem", {31'h0, bus.dmem_we}, 32'h0);
            tick();
        end
        check("fill_count", 32'(dut.count), 32'd4);
        check("fill_head", {24'h0, bus.tx_data}, 32'h41);
        drive(1'b1, 32'h81C, 32'h45);
        check("full_stall", {31'h0, bus.stall}, 32'h1);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check("pop_count", 32'(dut.count), 32'd3);
        check("pop_head", {24'h0, bus.tx_data}, 32'h42);
        check("retry_stall", {31'h0, bus.stall}, 32'h0);
        tick();
        check("retry_count", 32'(dut.count), 32'd4);
        drive(1'b0, 32'h0, 32'h0);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", {31'h0, bus.tx_valid}, 32'h1);
            check("drain_data", {24'h0, bus.tx_data}, {24'h0, drain[i]});
            tick();
        end
        check("drain_empty", {31'h0, bus.tx_valid}, 32'h0);

        // Streaming with tx_ready held high
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'h81C, i);
            check("stream_stall", {31'h0, bus.stall}, 32'h0);
            tick();
            check("stream_valid", {31'h0, bus.tx_valid}, 32'h1);
            check("stream_data", {24'h0, bus.tx_data}, i);
            check("stream_count", 32'(dut.count), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("stream_end", {31'h0, bus.tx_valid}, 32'h0);
        tick();
        check("ready_on_empty", 32'(dut.count), 32'd0);
        bus.tx_ready = 1'b0;

        // Reset with FIFO partly full
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h81C, 32'h61 + i);
            tick();
        end
        drive(1'b1, 32'h800, 32'h55);
        tick();
        check("pre_rst_led", bus.led, 32'h55);
        check("pre_rst_count", 32'(dut.count), 32'd3);
        rst = 1'b1;
        drive(1'b1, 32'h000, 32'h0);
        check("rst_dmem_comb", {31'h0, bus.dmem_we}, 32'h1);
        drive(1'b1, 32'h800, 32'hDEAD);
        tick();
        rst = 1'b0;
        check("mid_rst_led", bus.led, 32'h0);
        check("mid_rst_txvalid", {31'h0, bus.tx_valid}, 32'h0);
        check("mid_rst_count", 32'(dut.count), 32'd0);
        drive(1'b1, 32'h81C, 32'h77);
        check("post_rst_stall", {31'h0, bus.stall}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("post_rst_valid", {31'h0, bus.tx_valid}, 32'h1);
        check("post_rst_data", {24'h0, bus.tx_data}, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/write_select.md
WRITE_SELECT -- requirements
Module: write_select

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of TX byte entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port we  input  1  CPU store strobe, one store per cycle it is high.
REQ-005 SHALL have port addr  input  32  CPU store address.
REQ-006 SHALL have port wdata  input  32  CPU store data.
REQ-007 SHALL have port dmem_we  output  1  write enable to data memory.
REQ-008 SHALL have port led  output  32  LED register.
REQ-009 SHALL have port seg7  output  32  seven-segment display register.
REQ-010 SHALL have port timer_load  output  1  one-cycle pulse: load timer.
REQ-011 SHALL have port timer_value  output  32  timer reload value.
REQ-012 SHALL have port tx_data  output  8  byte at TX FIFO head.
REQ-013 SHALL have port tx_valid  output  1  TX FIFO non-empty.
REQ-014 SHALL have port tx_ready  input  1  consumer accepts tx_data this cycle.
REQ-015 SHALL have port stall  output  1  CPU must hold the current store and retry.

Function
REQ-016 SHALL decode a peripheral store only when addr[11]=1, matching on addr[11:0].
REQ-017 SHALL map 0x800 LED, 0x804 SEG7, 0x814 TIMER, 0x81C TX; these are write targets.
REQ-018 SHALL treat 0x808, 0x80C, 0x810, 0x818 as read-only: stores dropped, dmem_we=0, no state change.
REQ-019 SHALL drive dmem_we = we for every other address (addr[11]=0, or unmatched addr[11:0] with addr[11]=1), combinationally.
REQ-020 SHALL drive dmem_we=0 for all mapped addresses in REQ-017/REQ-018.
REQ-021 SHALL load led <= wdata on the edge after we with 0x800; seg7 likewise for 0x804.
REQ-022 SHALL, on we with 0x814, load timer_value <= wdata and assert timer_load for exactly the next cycle (registered pulse).
REQ-023 SHALL produce back-to-back timer_load pulses for stores to 0x814 in consecutive cycles, timer_value tracking each.
REQ-024 SHALL push wdata[7:0] into the TX FIFO on we with 0x81C when not full; wdata[31:8] ignored.
REQ-025 SHALL drive stall = we & (addr[11:0]==0x81C) & addr[11] & full, combinationally; stalled store not pushed.
REQ-026 SHALL compute full from registered count only; a pop in the same cycle does not unstall a push (no bypass).
REQ-027 SHALL drive tx_valid = (count!=0) and tx_data = entry at read pointer, both from registers.
REQ-028 SHALL pop one entry on a rising edge where tx_valid & tx_ready; tx_ready ignored when empty.
REQ-029 SHALL, on simultaneous push and pop with 0<count<FIFO_DEPTH, keep count unchanged and advance both pointers.
REQ-030 SHALL, on push into empty FIFO, present the byte with tx_valid=1 on the next cycle (1-cycle latency, no bypass).
REQ-031 SHALL wrap read/write pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-032 SHALL keep stall=0 for every store not targeting 0x81C, regardless of FIFO state.

Reset
REQ-033 SHALL, while rst=1 at a rising edge, set led=0, seg7=0, timer_value=0, timer_load=0, count=0, both pointers=0.
REQ-034 SHALL have tx_valid=0 the cycle after reset; FIFO contents discarded, including reset mid-transfer.
REQ-035 SHALL ignore we during reset cycles (no register update); dmem_we and stall still follow REQ-019/REQ-025 combinationally.

Verification
REQ-036 SHALL cover: store 0x12345678 to 0x800, then 0xA5 to 0x804 -> led=0x12345678, seg7=0x000000A5, dmem_we=0 both cycles.
REQ-037 SHALL cover: store 1000 to 0x814 -> timer_value=1000, timer_load high exactly one cycle; stores to 0x000 and 0x820 -> dmem_we=1, no register change.
REQ-038 SHALL cover: store to 0x80C with wdata=0xFFFFFFFF -> dmem_we=0, no output change.
REQ-039 SHALL cover: tx_ready=0, store 0x41,0x42,0x43,0x44 to 0x81C -> count=4, fifth store 0x45 gives stall=1; raise tx_ready one cycle -> 0x41 popped, retried 0x45 accepted next cycle; drain order 0x42,0x43,0x44,0x45.
REQ-040 SHALL cover: tx_ready=1 held, stores 0x01..0x08 every cycle -> bytes emitted in order, count never exceeds 1, stall never asserted.
REQ-041 SHALL cover: FIFO holding 3 bytes, led=0x55, assert rst one cycle -> led=0, tx_valid=0, next store to 0x81C accepted with no stall.
